grey_to_nature: RTL and testbench



---
 rtl/grey_to_nature.sv | 80 ++++++++
 tb/tb_grey_to_nature.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/grey_to_nature.sv
// grey_to_nature
//   Registered Gray-code to natural-binary converter. Intended for Gray values
//   that have already been synchronised into the local clock domain, such as
//   CDC FIFO pointers or encoder positions. The result is captured on each
//   enabled rising edge and held otherwise.
//
// Parameters
//   WIDTH       bit width of grey and nature. Legal range is 1..64.
//
// Ports
//   clk         rising-edge clock for all state
//   rst         asynchronous, active-high reset; clears every stage
//   en          conversion enable, sampled on rising clk
//   grey        Gray-coded input, sampled when en=1
//   nature      registered binary equivalent of the last enabled sample
//   nature_vld  high in each cycle where nature holds a freshly enabled result
//
// Build option
//   GREY2NATURE_PIPE_EN  When defined, an input register stage is added for
//                        grey and en. Latency then becomes 2 cycles. The port
//                        list is the same in both builds.

module grey_to_nature #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] grey,
  output logic [WIDTH-1:0] nature,
  output logic             nature_vld
);

  logic [WIDTH-1:0] src_grey;
  logic             src_en;
  logic [WIDTH-1:0] bin;

`ifdef GREY2NATURE_PIPE_EN
  logic [WIDTH-1:0] grey_q;
  logic             en_q;

  // Capture on every edge, regardless of en. The delayed en decides whether
  // the output stage loads or holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grey_q <= '0;
      en_q   <= 1'b0;
    end else begin
      grey_q <= grey;
      en_q   <= en;
    end
  end

  assign src_grey = grey_q;
  assign src_en   = en_q;
`else
  assign src_grey = grey;
  assign src_en   = en;
`endif

  // Binary bit i is the parity of all Gray bits from the MSB down to bit i.
  // Each bit is computed from its own slice of the input, so no bit of bin
  // depends on another bit of bin.
  for (genvar i = 0; i < WIDTH; i++) begin : g_conv
    assign bin[i] = ^src_grey[WIDTH-1:i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nature     <= '0;
      nature_vld <= 1'b0;
    end else begin
      nature_vld <= src_en;
      if (src_en) begin
        nature <= bin;
      end
    end
  end

endmodule

// File: tb/tb_grey_to_nature.sv
module tb_grey_to_nature;

  localparam int WIDTH = 4;
`ifdef GREY2NATURE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] grey = '0;
  logic [WIDTH-1:0] nature;
  logic             nature_vld;

  int checks = 0;
  int errors = 0;

  grey_to_nature #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .grey(grey),
    .nature(nature),
    .nature_vld(nature_vld)
  );

  always #5 clk = ~clk;

  // Gray -> binary: walk from the MSB keeping a running parity.
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] r;
    logic p;
    r = '0;
    p = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      p = p ^ g[i];
      r[i] = p;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: a queue of sampled (en, grey) pairs. The output stage
  // acts on the sample that is LAT-1 edges old. Reset empties everything.
  logic [WIDTH-1:0] exp_n = '0;
  logic             exp_v = 1'b0;
  logic [WIDTH:0]   hist[$];

  initial begin
    for (int i = 0; i < LAT - 1; i++) hist.push_back('0);
  end

  always @(posedge clk or posedge rst) begin
    logic [WIDTH:0] s;
    if (rst) begin
      exp_n = '0;
      exp_v = 1'b0;
      hist.delete();
      for (int i = 0; i < LAT - 1; i++) hist.push_back('0);
    end else begin
      hist.push_back({en, grey});
      s = hist.pop_front();
      exp_v = s[WIDTH];
      if (s[WIDTH]) exp_n = g2b(s[WIDTH-1:0]);
    end
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    check("nature_vs_model", {60'd0, nature}, {60'd0, exp_n});
    check("vld_vs_model", {63'd0, nature_vld}, {63'd0, exp_v});
  end

  logic [WIDTH-1:0] gv[7] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b1111, 4'b1000};
  logic [WIDTH-1:0] nv[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1010, 4'b1111};

  initial begin
    // Come out of power-on reset, then load 1111 and assert reset mid-cycle.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; en = 1'b1; grey = 4'b1111;
    repeat (LAT + 1) @(posedge clk);
    #1 check("pre_reset_load", {60'd0, nature}, 64'h0a);
    #2 rst = 1'b1;
    #1 check("reset_async_nature", {60'd0, nature}, 64'h0);
    check("reset_async_vld", {63'd0, nature_vld}, 64'h0);
    repeat (2) @(posedge clk);
    #1 check("reset_held_nature", {60'd0, nature}, 64'h0);
    rst = 1'b0; en = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1 check("released_no_en", {60'd0, nature}, 64'h0);
    check("released_no_en_vld", {63'd0, nature_vld}, 64'h0);

    // Basic map. The sample driven in iteration j becomes visible at iteration j+LAT.
    for (int k = 0; k < 7 + LAT; k++) begin
      if (k > 0) @(posedge clk);
      #1;
      if (k >= LAT) begin
        check("basic_map", {60'd0, nature}, {60'd0, nv[k-LAT]});
        check("basic_map_vld", {63'd0, nature_vld}, 64'h1);
      end
      if (k < 7) begin
        en = 1'b1; grey = gv[k];
      end else begin
        en = 1'b0;
      end
    end

    // Hold: load 0110, then drop en while driving 1111.
    @(posedge clk);
    #1 en = 1'b1; grey = 4'b0110;
    repeat (LAT) @(posedge clk);
    #1 check("hold_load", {60'd0, nature}, 64'h4);
    en = 1'b0; grey = 4'b1111;
    repeat (3 + LAT - 1) @(posedge clk);
    #1 check("hold_nature", {60'd0, nature}, 64'h4);
    check("hold_vld", {63'd0, nature_vld}, 64'h0);

    // Free-running sweep with a one-cycle reset pulse in the middle.
    // A second pass after the pulse covers the 1111 -> 0000 wrap in one stream.
    en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 0; v < 16; v++) begin
        @(posedge clk);
        #1 grey = v[WIDTH-1:0];
        if (pass == 0 && v == 8) begin
          #2 rst = 1'b1;
          #1 check("midstream_reset_nature", {60'd0, nature}, 64'h0);
          check("midstream_reset_vld", {63'd0, nature_vld}, 64'h0);
          @(posedge clk);
          #1 rst = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1 grey = 4'b0000;
    repeat (LAT) @(posedge clk);
    #1 check("wrap_to_zero", {60'd0, nature}, 64'h0);
    check("wrap_vld", {63'd0, nature_vld}, 64'h1);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
